ps2_key_decoder: RTL and testbench

- Sits directly downstream of keyboard_PS2 and consumes its byte stream (dat_out, dat_ready).
- Decodes PS/2 Set-2 scancode sequences (plain, E0-extended, F0 break, E1 pause) into make/break events.
- Maintains held-key flags for the game controls (arrows, space, enter, esc) that the game logic samples directly.

---
 rtl/ps2_pkg.sv | 54 +++++
 rtl/ps2_key_map.sv | 32 +++
 rtl/ps2_key_decoder.sv | 182 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scancode constants, FSM encodings and key indices for the PS/2 Set-2 key decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BRK        = 8'hF0;
  localparam logic [7:0] SC_PAUSE      = 8'hE1;
  localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;

  // Game keys; the arrows only count when E0-prefixed.
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Controller/status bytes that carry no key information.
  localparam int unsigned NUM_IGNORED = 6;
  localparam logic [7:0] IGNORED_BYTES [NUM_IGNORED] = '{
    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF
  };

  localparam int unsigned NUM_KEYS = 7;

  typedef enum logic [2:0] {
    KEY_LEFT  = 3'd0,
    KEY_RIGHT = 3'd1,
    KEY_UP    = 3'd2,
    KEY_DOWN  = 3'd3,
    KEY_SPACE = 3'd4,
    KEY_ENTER = 3'd5,
    KEY_ESC   = 3'd6
  } key_idx_e;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;

  // Bytes following E1 in the Pause make sequence.
  localparam logic [2:0] SKIP_PAUSE = 3'd7;

  function automatic logic is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_IGNORED; i++) begin
      if (b == IGNORED_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_map.sv
// Maps a completed (ext, code) pair onto the one-hot game-key index.
module ps2_key_map
  import ps2_pkg::*;
(
  input  logic                ext,
  input  logic [7:0]          code,
  output logic [NUM_KEYS-1:0] key_onehot,
  output logic                mapped
);

  always_comb begin
    key_onehot = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  key_onehot[KEY_LEFT]  = 1'b1;
        SC_RIGHT: key_onehot[KEY_RIGHT] = 1'b1;
        SC_UP:    key_onehot[KEY_UP]    = 1'b1;
        SC_DOWN:  key_onehot[KEY_DOWN]  = 1'b1;
        default:  key_onehot = '0;
      endcase
    end else begin
      case (code)
        SC_SPACE: key_onehot[KEY_SPACE] = 1'b1;
        SC_ENTER: key_onehot[KEY_ENTER] = 1'b1;
        SC_ESC:   key_onehot[KEY_ESC]   = 1'b1;
        default:  key_onehot = '0;
      endcase
    end
    mapped = |key_onehot;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 Set-2 byte sequences into make/break pulses and held flags for the game keys.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 250000,
  parameter bit          REPEAT_FILTER  = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] dat_in,
  input  logic       dat_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_make,
  output logic       key_break,
  output logic       seq_error,
  output logic       key_left,
  output logic       key_right,
  output logic       key_up,
  output logic       key_down,
  output logic       key_space,
  output logic       key_enter,
  output logic       key_esc
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [7:0]          key_code_q;
  logic                key_ext_q;
  logic                key_make_q, key_break_q, seq_error_q;
  logic [NUM_KEYS-1:0] flags_q, flags_d;

  logic                ev_valid, ev_make, ev_ext;
  logic                timeout;
  logic                repeat_hit;
  logic                make_pulse;
  logic [NUM_KEYS-1:0] key_onehot;
  logic                mapped;

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign timeout = (state_q != ST_IDLE) && (timer_q == TimerLast) && !dat_ready;

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    ev_valid = 1'b0;
    ev_make  = 1'b0;
    ev_ext   = 1'b0;
    if (dat_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (dat_in == SC_EXT) begin
            state_d = ST_EXT;
          end else if (dat_in == SC_BRK) begin
            state_d = ST_BRK;
          end else if (dat_in == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_PAUSE;
          end else if (!is_ignored(dat_in)) begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
          end
        end
        ST_EXT: begin
          if (dat_in == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (dat_in != SC_EXT) begin
            state_d = ST_IDLE;
            if (dat_in != SC_FAKE_SHIFT) begin
              ev_valid = 1'b1;
              ev_make  = 1'b1;
              ev_ext   = 1'b1;
            end
          end
        end
        ST_BRK: begin
          state_d  = ST_IDLE;
          ev_valid = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (dat_in != SC_FAKE_SHIFT) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
          end
        end
        ST_SKIP: begin
          if (skip_q <= 3'd1) begin
            state_d = ST_IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          skip_d  = '0;
        end
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
      skip_d  = '0;
    end
  end

  always_comb begin
    if (dat_ready || timeout || (state_q == ST_IDLE)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  ps2_key_map u_key_map (
    .ext        (ev_ext),
    .code       (dat_in),
    .key_onehot (key_onehot),
    .mapped     (mapped)
  );

  // Typematic repeats of a key already held are not reported as new makes.
  assign repeat_hit = REPEAT_FILTER && mapped && |(flags_q & key_onehot);
  assign make_pulse = ev_valid && ev_make && !repeat_hit;

  always_comb begin
    flags_d = flags_q;
    if (ev_valid) begin
      if (ev_make) flags_d = flags_q | key_onehot;
      else         flags_d = flags_q & ~key_onehot;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      timer_q <= timer_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_make_q  <= 1'b0;
      key_break_q <= 1'b0;
      seq_error_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      key_make_q  <= make_pulse;
      key_break_q <= ev_valid && !ev_make;
      seq_error_q <= timeout;
      flags_q     <= flags_d;
      if (ev_valid) begin
        key_code_q <= dat_in;
        key_ext_q  <= ev_ext;
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_make  = key_make_q;
  assign key_break = key_break_q;
  assign seq_error = seq_error_q;
  assign key_left  = flags_q[KEY_LEFT];
  assign key_right = flags_q[KEY_RIGHT];
  assign key_up    = flags_q[KEY_UP];
  assign key_down  = flags_q[KEY_DOWN];
  assign key_space = flags_q[KEY_SPACE];
  assign key_enter = flags_q[KEY_ENTER];
  assign key_esc   = flags_q[KEY_ESC];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed byte sequences, expected events queued, monitor compares.
module tb_ps2_key_decoder;

  localparam int unsigned TO = 100;

  logic       clock;
  logic       reset_n;
  logic [7:0] dat_in;
  logic       dat_ready;
  logic [7:0] key_code;
  logic       key_ext, key_make, key_break, seq_error;
  logic       key_left, key_right, key_up, key_down, key_space, key_enter, key_esc;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES (TO),
    .REPEAT_FILTER  (1'b1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .dat_in    (dat_in),
    .dat_ready (dat_ready),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_make  (key_make),
    .key_break (key_break),
    .seq_error (seq_error),
    .key_left  (key_left),
    .key_right (key_right),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_space (key_space),
    .key_enter (key_enter),
    .key_esc   (key_esc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pcyc = 0;
  always @(posedge clock) pcyc <= pcyc + 1;

  int checks   = 0;
  int failures = 0;

  localparam int K_MAKE = 0;
  localparam int K_BRK  = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] code;
    logic       ext;
    logic [6:0] flags;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] act_flags;
  assign act_flags = {key_esc, key_enter, key_space, key_down, key_up, key_right, key_left};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input string name, input int kind, input logic [7:0] code,
                           input logic ext, input logic [6:0] flags, input int cyc);
    exp_t e;
    e.name = name; e.kind = kind; e.code = code; e.ext = ext; e.flags = flags; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Call at a negedge; strobes one byte and returns at the next negedge.
  task automatic send(input logic [7:0] b);
    dat_in    = b;
    dat_ready = 1'b1;
    @(negedge clock);
    dat_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every cycle with a pulse must match the head of the queue.
  always @(negedge clock) begin
    if (reset_n && (key_make || key_break || seq_error)) begin
      int   kind;
      exp_t e;
      kind = key_make ? K_MAKE : (key_break ? K_BRK : K_ERR);
      chk("make_break_exclusive", {31'd0, key_make & key_break}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got kind=%0d code=0x%0h ext=%0b at cyc %0d, expected none",
                 kind, key_code, key_ext, pcyc);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_kind"}, kind, e.kind);
        chk({e.name, "_cycle"}, pcyc, e.cyc);
        chk({e.name, "_flags"}, {25'd0, act_flags}, {25'd0, e.flags});
        if (e.kind != K_ERR) begin
          chk({e.name, "_code"}, {24'd0, key_code}, {24'd0, e.code});
          chk({e.name, "_ext"}, {31'd0, key_ext}, {31'd0, e.ext});
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    dat_in    = 8'h00;
    dat_ready = 1'b0;
    idle(3);
    chk("reset_outputs", {17'd0, key_code, key_ext, key_make, key_break, seq_error, act_flags}, 32'd0);
    reset_n = 1'b1;
    idle(2);
    chk("post_reset_outputs", {17'd0, key_code, key_ext, key_make, key_break, seq_error, act_flags},
        32'd0);

    // Space make / break
    expect_ev("space_make", K_MAKE, 8'h29, 1'b0, 7'h10, pcyc + 1);
    send(8'h29); idle(3);
    send(8'hF0);
    expect_ev("space_break", K_BRK, 8'h29, 1'b0, 7'h00, pcyc + 1);
    send(8'h29); idle(3);

    // Up arrow with typematic repeat filtered
    send(8'hE0);
    expect_ev("up_make", K_MAKE, 8'h75, 1'b1, 7'h04, pcyc + 1);
    send(8'h75); idle(3);
    send(8'hE0); send(8'h75); idle(3);
    send(8'hE0); send(8'hF0);
    expect_ev("up_break", K_BRK, 8'h75, 1'b1, 7'h00, pcyc + 1);
    send(8'h75); idle(3);
    expect_ev("kp8_make", K_MAKE, 8'h75, 1'b0, 7'h00, pcyc + 1);
    send(8'h75); idle(3);

    // Abandoned E0 times out, then plain Enter
    expect_ev("timeout", K_ERR, 8'h00, 1'b0, 7'h00, pcyc + TO + 1);
    send(8'hE0); idle(TO + 10);
    expect_ev("enter_make", K_MAKE, 8'h5A, 1'b0, 7'h20, pcyc + 1);
    send(8'h5A); idle(3);

    // Pause sequence produces nothing, then Esc
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); idle(3);
    expect_ev("esc_make", K_MAKE, 8'h76, 1'b0, 7'h60, pcyc + 1);
    send(8'h76); idle(3);

    // Print screen: fake shift discarded
    send(8'hE0); send(8'h12); send(8'hE0);
    expect_ev("prtscr_make", K_MAKE, 8'h7C, 1'b0 | 1'b1, 7'h60, pcyc + 1);
    send(8'h7C); idle(3);

    // Byte lands on the exact expiry cycle: processed, no seq_error
    send(8'hE0); idle(TO - 1);
    expect_ev("edge_byte_make", K_MAKE, 8'h5A, 1'b1, 7'h60, pcyc + 1);
    send(8'h5A); idle(TO + 10);

    // Break of a key not held
    send(8'hF0);
    expect_ev("space_break_unheld", K_BRK, 8'h29, 1'b0, 7'h60, pcyc + 1);
    send(8'h29); idle(3);

    // Hold left, start a sequence, reset mid-way
    send(8'hE0);
    expect_ev("left_make", K_MAKE, 8'h6B, 1'b1, 7'h61, pcyc + 1);
    send(8'h6B); idle(3);
    send(8'hE0); idle(2);
    chk("queue_drained_before_reset", exp_q.size(), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {17'd0, key_code, key_ext, key_make, key_break, seq_error, act_flags},
        32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    send(8'hF0);
    expect_ev("plain_6b_break", K_BRK, 8'h6B, 1'b0, 7'h00, pcyc + 1);
    send(8'h6B);
    idle(TO + 50);

    chk("queue_empty_at_end", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
